// File: rtl/timer_dev_pkg.sv
// -----------------------------------------------------------------------------
// timer_dev_pkg
//   Shared constants for the memory-mapped countdown timer:
//     - register word offsets (bridge address bits [3:2])
//     - FSM state encoding
//     - CTRL mode codes and CTRL bit positions
//     - helper that decodes whether a MODE value means auto-reload
// -----------------------------------------------------------------------------
package timer_dev_pkg;

  // Register word offsets
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  // FSM states
  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_INT  = 2'd3
  } tmr_state_e;

  // CTRL.MODE codes; 2'b1x is reserved and behaves as one-shot
  localparam logic [1:0] TMR_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TMR_MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Only the exact auto-reload code reloads; everything else is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == TMR_MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
//   Memory-mapped countdown timer on the device side of the CPU bridge.
//   Three registers (CTRL, PRESET, COUNT) plus an IDLE/LOAD/CNT/INT FSM that
//   counts COUNT down from PRESET and raises an interrupt on expiry.
//
//   Ports:
//     clk    in   system clock, rising-edge
//     reset  in   asynchronous active-low reset
//     addr   in   [1:0]  word offset within the device
//     we     in   write strobe, already address/interrupt qualified
//     wdata  in   [31:0] write data
//     rdata  out  [31:0] read data, combinational from addr
//     irq    out  registered interrupt request (IM & pending)
//
//   Bus protocol: single-cycle access, no handshake. A write commits on the
//   rising edge where we=1; a read is a pure function of addr and the current
//   register contents. The FSM always works from pre-edge register values, so
//   a bus write becomes visible to the FSM one cycle later.
//
//   The FSM state is held in `state_q` (type tmr_state_e) for checkers to bind.
// -----------------------------------------------------------------------------
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tmr_state_e  state_q,   state_d;
  logic        en_q,      en_d;
  logic [1:0]  mode_q,    mode_d;
  logic        im_q,      im_d;
  logic [31:0] preset_q,  preset_d;
  logic [31:0] count_q,   count_d;
  logic        pending_q, pending_d;
  logic        irq_d;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        hw_set_pending;
  logic        hw_clr_pending;
  logic        hw_clr_en;

  assign wr_ctrl   = we && (addr == TMR_CTRL);
  assign wr_preset = we && (addr == TMR_PRESET);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TMR_IDLE;
      en_q      <= 1'b0;
      mode_q    <= TMR_MODE_ONESHOT;
      im_q      <= 1'b0;
      preset_q  <= PRESET_RST;
      count_q   <= 32'h0;
      pending_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq       <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, counter, and bus write merge
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    en_d           = en_q;
    mode_d         = mode_q;
    im_d           = im_q;
    preset_d       = preset_q;
    count_d        = count_q;
    pending_d      = pending_q;
    hw_set_pending = 1'b0;
    hw_clr_pending = 1'b0;
    hw_clr_en      = 1'b0;

    case (state_q)
      TMR_IDLE: begin
        if (en_q) state_d = TMR_LOAD;
      end
      TMR_LOAD: begin
        count_d = preset_q;
        state_d = TMR_CNT;
      end
      TMR_CNT: begin
        if (!en_q) begin
          state_d = TMR_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Reaching 1 (or a PRESET of 0) ends the period this edge.
          count_d        = 32'h0;
          hw_set_pending = 1'b1;
          state_d        = TMR_INT;
        end
      end
      TMR_INT: begin
        if (is_reload(mode_q)) begin
          hw_clr_pending = 1'b1;
          state_d        = TMR_LOAD;
        end else begin
          hw_clr_en = 1'b1;
          state_d   = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase

    // A software CTRL write on the same edge overrides the hardware EN clear.
    if (hw_clr_en) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d   = wdata[CTRL_EN_BIT];
      mode_d = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      im_d   = wdata[CTRL_IM_BIT];
    end

    // PRESET only feeds COUNT in LOAD, so a write mid-count leaves the
    // running count alone and is picked up at the next reload.
    if (wr_preset) preset_d = wdata;

    // Expiry sets pending even if software clears it on the same edge.
    if (hw_set_pending) begin
      pending_d = 1'b1;
    end else if (hw_clr_pending || wr_ctrl || wr_preset) begin
      pending_d = 1'b0;
    end

    // irq is registered from the next-state values so it always equals
    // IM & pending of the current cycle, with no combinational path out.
    irq_d = im_d & pending_d;
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = 32'h0;
    case (addr)
      TMR_CTRL:   rdata = {28'h0, im_q, mode_q, en_q};
      TMR_PRESET: rdata = preset_q;
      TMR_COUNT:  rdata = count_q;
      default:    rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// -----------------------------------------------------------------------------
// tb_timer_dev
//   Directed testbench for timer_dev. Inputs are driven 1 time unit after the
//   rising edge; outputs are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_timer_dev;

  localparam logic [31:0] RST_PRESET = 32'h0000_0064;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  timer_dev #(.PRESET_RST(RST_PRESET)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    chk(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  // Auto-reload, PRESET=3: COUNT / irq after edges E2..E11 of the CTRL write
  logic [31:0] reload_cnt[10] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
                                  32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
  logic        reload_irq[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // 1. Reset values
    rd_chk("rst_ctrl",   2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, RST_PRESET);
    rd_chk("rst_count",  2'd2, 32'h0);
    rd_chk("rst_off3",   2'd3, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // 2. One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                  // E0
    tick();                           // E1 LOAD
    tick();                           // E2 CNT
    rd_chk("os_cnt5", 2'd2, 32'd5);
    for (int k = 4; k >= 1; k--) begin
      tick();
      rd_chk($sformatf("os_cnt%0d", k), 2'd2, k);
      irq_chk("os_irq_lo", 1'b0);
    end
    tick();                           // E7 INT
    rd_chk("os_cnt0", 2'd2, 32'd0);
    irq_chk("os_irq_e7", 1'b1);
    tick();                           // E8 IDLE, EN cleared
    rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
    irq_chk("os_irq_held1", 1'b1);
    tick();
    tick();
    irq_chk("os_irq_held2", 1'b1);
    wr(2'd1, 32'd5);                  // PRESET write clears pending
    irq_chk("os_irq_clr", 1'b0);

    // Boundary: PRESET=1 expires 3 edges after EN
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick();
    tick();
    irq_chk("p1_irq_e2", 1'b0);
    tick();
    irq_chk("p1_irq_e3", 1'b1);
    tick();
    irq_chk("p1_irq_held", 1'b1);

    // Boundary: PRESET=0 also expires 3 edges after EN
    wr(2'd1, 32'd0);
    irq_chk("p0_irq_clr", 1'b0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    irq_chk("p0_irq_e2", 1'b0);
    rd_chk("p0_cnt", 2'd2, 32'd0);
    tick();
    irq_chk("p0_irq_e3", 1'b1);

    // CTRL write in the INT cycle beats the hardware EN clear
    wr(2'd0, 32'h9);
    rd_chk("int_wr_ctrl", 2'd0, 32'h9);
    irq_chk("int_wr_irq", 1'b0);
    tick();                           // LOAD
    tick();                           // CNT
    tick();                           // INT again
    irq_chk("int_wr_restart", 1'b1);
    tick();                           // IDLE, EN cleared
    wr(2'd1, 32'd3);

    // 3. Auto-reload, PRESET=3, IM=1
    wr(2'd0, 32'hB);                  // E0
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();                         // E2 .. E11
      rd_chk($sformatf("ar_cnt_e%0d", i + 2), 2'd2, reload_cnt[i]);
      irq_chk($sformatf("ar_irq_e%0d", i + 2), reload_irq[i]);
    end
    tick();                           // E12 CNT count 3
    wr(2'd1, 32'd7);                  // E13 PRESET write mid-count
    rd_chk("ar_preset_no_effect", 2'd2, 32'd2);
    tick();                           // E14 count 1
    tick();                           // E15 INT
    irq_chk("ar_irq_e15", 1'b1);
    tick();                           // E16 LOAD
    tick();                           // E17 CNT, new preset
    rd_chk("ar_new_preset", 2'd2, 32'd7);
    wr(2'd0, 32'h0);                  // still decrements this edge -> 6
    tick();                           // IDLE, holds
    rd_chk("ar_stop_hold", 2'd2, 32'd6);

    // 4. Mid-count disable freezes COUNT; re-enable restarts from PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick();
    tick();
    rd_chk("mid_cnt10", 2'd2, 32'd10);
    wr(2'd0, 32'h0);
    rd_chk("mid_cnt9", 2'd2, 32'd9);
    tick();
    tick();
    rd_chk("mid_frozen", 2'd2, 32'd9);
    irq_chk("mid_no_irq", 1'b0);
    wr(2'd0, 32'h1);
    tick();
    rd_chk("mid_load_hold", 2'd2, 32'd9);
    tick();
    rd_chk("mid_restart", 2'd2, 32'd10);
    wr(2'd0, 32'h0);
    tick();

    // 5. IM=0 expiry, then enabling IM via a CTRL write clears pending
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    repeat (4) tick();                // INT
    rd_chk("im0_cnt0", 2'd2, 32'd0);
    irq_chk("im0_irq", 1'b0);
    tick();
    rd_chk("im0_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    irq_chk("im0_wr_clr", 1'b0);
    tick();
    irq_chk("im0_wr_clr2", 1'b0);

    // 6a. Async reset while irq is held
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    irq_chk("ar6_irq_pre", 1'b1);
    #2;
    reset = 1'b0;
    #1;
    irq_chk("ar6_irq_async", 1'b0);
    rd_chk("ar6_ctrl_async", 2'd0, 32'h0);
    rd_chk("ar6_preset_async", 2'd1, RST_PRESET);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 6b. Async reset mid-count, then COUNT/offset-3 writes ignored
    wr(2'd1, 32'd20);
    wr(2'd0, 32'hB);
    repeat (4) tick();
    rd_chk("cnt6_pre", 2'd2, 32'd18);
    #1;
    reset = 1'b0;
    #1;
    rd_chk("cnt6_count_async", 2'd2, 32'h0);
    rd_chk("cnt6_preset_async", 2'd1, RST_PRESET);
    irq_chk("cnt6_irq_async", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    wr(2'd2, 32'hFFFF);
    rd_chk("count_ro", 2'd2, 32'h0);
    wr(2'd3, 32'h1234);
    rd_chk("off3_ro", 2'd3, 32'h0);
    rd_chk("off3_ctrl", 2'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
